// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the ALU decoder and the
// execution slice.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b1010;
   localparam logic [3:0] ALU_SLT = 4'b1011;
   localparam logic [3:0] ALU_ROR = 4'b0100;
   localparam logic [3:0] ALU_ROL = 4'b0101;
   localparam logic [3:0] ALU_NOR = 4'b0110;
   localparam logic [3:0] ALU_MUL = 4'b0111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and zero flag for every alucontrol code.
// Unassigned codes produce an all-zero result so nothing unknown escapes.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic [3:0]       alucontrol,
   output logic [WIDTH-1:0] aluresult,
   output logic             zero
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0]     W_AMT = (SHW+1)'(WIDTH);
   localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [SHW-1:0]   sh_s;
   logic [SHW:0]     csh_s;
   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] diff_s;
   logic [WIDTH-1:0] prod_s;
   logic [WIDTH-1:0] ror_s;
   logic [WIDTH-1:0] rol_s;
   logic             slt_s;
   logic [WIDTH-1:0] result_s;

   // Shared arithmetic, compare and rotate terms feeding the result mux.
   // The complementary shift is WIDTH when the rotate amount is 0, which
   // shifts everything out and leaves a unchanged.
   always_comb begin
      sh_s   = srcb[SHW-1:0];
      csh_s  = W_AMT - {1'b0, sh_s};
      sum_s  = srca + srcb;
      diff_s = srca + ~srcb + ONE;
      prod_s = srca * srcb;
      ror_s  = (srca >> sh_s) | (srca << csh_s);
      rol_s  = (srca << sh_s) | (srca >> csh_s);
      slt_s  = ($signed(srca) < $signed(srcb));
   end

   // Operation select; zero is taken from the final result for every code.
   always_comb begin
      result_s = {WIDTH{1'b0}};
      case (alucontrol)
         ALU_AND: result_s = srca & srcb;
         ALU_OR:  result_s = srca | srcb;
         ALU_ADD: result_s = sum_s;
         ALU_SUB: result_s = diff_s;
         ALU_SLT: result_s = {{(WIDTH-1){1'b0}}, slt_s};
         ALU_ROR: result_s = ror_s;
         ALU_ROL: result_s = rol_s;
         ALU_NOR: result_s = ~(srca | srcb);
         ALU_MUL: result_s = prod_s;
         default: result_s = {WIDTH{1'b0}};
      endcase
      aluresult = result_s;
      zero      = (result_s == {WIDTH{1'b0}});
   end

endmodule

// File: rtl/dff_regs.sv
// Generic WIDTH-bit registers with asynchronous active-high reset:
// dff_rst always loads, dff_rst_en loads only when en is high.
module dff_rst #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Load every rising edge; reset clears immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= {WIDTH{1'b0}};
      else       q <= d;
   end

endmodule

module dff_rst_en #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Load on rising edge when enabled, otherwise hold; reset clears immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   q <= {WIDTH{1'b0}};
      else if (en) q <= d;
      else         q <= q;
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution slice of the multicycle datapath: combinational ALU plus the
// ALUOut register (loads every cycle) and the enabled hold register.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic [3:0]       alucontrol,
   input  logic             en,
   output logic [WIDTH-1:0] aluresult,
   output logic             zero,
   output logic [WIDTH-1:0] aluout,
   output logic [WIDTH-1:0] holdq
);

   logic [WIDTH-1:0] result_s;

   alu_core #(.WIDTH(WIDTH)) u_alu_core (
      .srca       (srca),
      .srcb       (srcb),
      .alucontrol (alucontrol),
      .aluresult  (result_s),
      .zero       (zero)
   );

   assign aluresult = result_s;

   dff_rst #(.WIDTH(WIDTH)) u_aluout_reg (
      .clk   (clk),
      .reset (reset),
      .d     (result_s),
      .q     (aluout)
   );

   dff_rst_en #(.WIDTH(WIDTH)) u_hold_reg (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (result_s),
      .q     (holdq)
   );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a behavioural ALU/register model
// checked every negative edge, plus directed vectors with literal results.
module tb_alu_exec_unit;

   logic        clk;
   logic        reset;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic [3:0]  alucontrol;
   logic        en;
   logic [31:0] aluresult;
   logic        zero;
   logic [31:0] aluout;
   logic [31:0] holdq;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   logic [31:0] m_aluout;
   logic [31:0] m_holdq;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .srca       (srca),
      .srcb       (srcb),
      .alucontrol (alucontrol),
      .en         (en),
      .aluresult  (aluresult),
      .zero       (zero),
      .aluout     (aluout),
      .holdq      (holdq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU written from the operation table with plain arithmetic.
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
      logic [31:0] r;
      logic [63:0] p;
      longint      sa;
      longint      sb;
      int          n;
      r  = 32'h0;
      n  = int'(b % 32'd32);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b1010: r = a - b;
         4'b1011: r = (sa < sb) ? 32'd1 : 32'd0;
         4'b0100: begin
            r = a;
            for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
         end
         4'b0101: begin
            r = a;
            for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
         end
         4'b0110: r = ~(a | b);
         4'b0111: begin
            p = {32'h0, a} * {32'h0, b};
            r = p[31:0];
         end
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the two registers.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_aluout <= 32'h0;
         m_holdq  <= 32'h0;
      end else begin
         m_aluout <= ref_alu(srca, srcb, alucontrol);
         if (en) m_holdq <= ref_alu(srca, srcb, alucontrol);
      end
   end

   // Compare DUT against the model every negative edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("model_result", aluresult, ref_alu(srca, srcb, alucontrol));
         check("model_zero", {31'h0, zero}, {31'h0, ref_alu(srca, srcb, alucontrol) == 32'h0});
         check("model_aluout", aluout, m_aluout);
         check("model_holdq", holdq, m_holdq);
      end
   end

   task automatic apply(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic e);
      @(posedge clk);
      #2;
      srca       = a;
      srcb       = b;
      alucontrol = op;
      en         = e;
   endtask

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] r;
   } vec_t;

   vec_t vecs[17];
   logic [3:0] undef_ops[7];

   initial begin
      vecs[0]  = '{"sub_eq",     32'd5,         32'd5,         4'b1010, 32'h0};
      vecs[1]  = '{"sub_neg",    32'd3,         32'd5,         4'b1010, 32'hFFFFFFFE};
      vecs[2]  = '{"and",        32'hF0F0F0F0,  32'hFF00FF00,  4'b0000, 32'hF000F000};
      vecs[3]  = '{"or",         32'hF0F0F0F0,  32'hFF00FF00,  4'b0001, 32'hFFF0FFF0};
      vecs[4]  = '{"nor",        32'h0,         32'h0,         4'b0110, 32'hFFFFFFFF};
      vecs[5]  = '{"slt_m1_1",   32'hFFFFFFFF,  32'd1,         4'b1011, 32'd1};
      vecs[6]  = '{"slt_1_m1",   32'd1,         32'hFFFFFFFF,  4'b1011, 32'd0};
      vecs[7]  = '{"slt_ovf",    32'h80000000,  32'd1,         4'b1011, 32'd1};
      vecs[8]  = '{"slt_eq",     32'd7,         32'd7,         4'b1011, 32'd0};
      vecs[9]  = '{"ror_1",      32'h00000001,  32'd1,         4'b0100, 32'h80000000};
      vecs[10] = '{"rol_1",      32'h80000000,  32'd1,         4'b0101, 32'h00000001};
      vecs[11] = '{"ror_32",     32'h12345678,  32'h20,        4'b0100, 32'h12345678};
      vecs[12] = '{"rol_hi_b",   32'h12345678,  32'h24,        4'b0101, 32'h23456781};
      vecs[13] = '{"ror_8",      32'h12345678,  32'd8,         4'b0100, 32'h78123456};
      vecs[14] = '{"mul_wrap",   32'h00010000,  32'h00010000,  4'b0111, 32'h0};
      vecs[15] = '{"mul_6_7",    32'd6,         32'd7,         4'b0111, 32'd42};
      vecs[16] = '{"add_carry",  32'hFFFFFFFF,  32'd1,         4'b0010, 32'h0};
      undef_ops = '{4'b0011, 4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

      reset = 1'b1; srca = 32'h0; srcb = 32'h0; alucontrol = 4'b0000; en = 1'b0;
      #1;
      check("reset_aluout", aluout, 32'h0);
      check("reset_holdq", holdq, 32'h0);
      @(posedge clk); @(posedge clk); #2;
      reset  = 1'b0;
      chk_on = 1'b1;

      // Asynchronous reset mid-run.
      apply(32'h12345678, 32'h0, 4'b0001, 1'b1);
      @(posedge clk); #1;
      check("preload_aluout", aluout, 32'h12345678);
      check("preload_holdq", holdq, 32'h12345678);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_aluout", aluout, 32'h0);
      check("async_rst_holdq", holdq, 32'h0);
      @(posedge clk); #1;
      check("rst_dom_aluout", aluout, 32'h0);
      check("rst_dom_holdq", holdq, 32'h0);
      #1;
      reset = 1'b0;
      srca = 32'd5; srcb = 32'd7; alucontrol = 4'b0010; en = 1'b1;
      #1;
      check("add_result", aluresult, 32'd12);
      @(posedge clk); #1;
      check("first_edge_aluout", aluout, 32'd12);
      check("first_edge_holdq", holdq, 32'd12);

      // Directed combinational vectors.
      foreach (vecs[i]) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0);
         @(negedge clk); #1;
         check(vecs[i].name, aluresult, vecs[i].r);
         check({vecs[i].name, "_zero"}, {31'h0, zero}, {31'h0, vecs[i].r == 32'h0});
      end

      // Hold register enable behaviour.
      apply(32'hAA, 32'h0, 4'b0010, 1'b1);
      @(posedge clk); #1;
      check("hold_load", holdq, 32'hAA);
      for (int k = 1; k <= 3; k++) begin
         apply(32'h100 * k, 32'd1, 4'b0010, 1'b0);
         @(posedge clk); #1;
         check("hold_keep", holdq, 32'hAA);
         check("hold_aluout", aluout, 32'h100 * k + 32'd1);
      end
      apply(32'h55, 32'h0, 4'b0001, 1'b1);
      @(posedge clk); #1;
      check("hold_reload", holdq, 32'h55);

      // Unassigned codes give zero result and zero flag.
      foreach (undef_ops[i]) begin
         apply(32'hDEADBEEF, 32'h12345678, undef_ops[i], 1'b1);
         @(negedge clk); #1;
         check("undef_result", aluresult, 32'h0);
         check("undef_zero", {31'h0, zero}, 32'd1);
      end
      @(posedge clk); #1;
      check("undef_aluout", aluout, 32'h0);

      @(negedge clk);
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execution slice of the multicycle MIPS datapath. It contains a combinational WIDTH-bit ALU with a zero flag, plus two state registers:
- ALUOut: loads every cycle.
- Hold register: loads only when enabled, used for PC-style capture of the ALU result.
Control comes from the ALU decoder's 4-bit alucontrol; operands come from the srca/srcb muxes.

Parameters:
WIDTH, 32, datapath width in bits for operands, result and both registers (minimum 8, power of two).

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high; clears both registers
srca  input  WIDTH  ALU operand A
srcb  input  WIDTH  ALU operand B
alucontrol  input  4  operation select
en  input  1  load enable for the hold register
aluresult  output  WIDTH  combinational ALU result
zero  output  1  combinational; 1 when aluresult equals 0
aluout  output  WIDTH  registered aluresult, loaded every cycle
holdq  output  WIDTH  registered aluresult, loaded only when en=1

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- ALU is purely combinational, with zero latency from srca/srcb/alucontrol to aluresult/zero.
- ALU operation codes:
  - 0000 AND: a&b
  - 0001 OR: a|b
  - 0010 ADD: a+b, modulo 2^WIDTH, carry discarded
  - 1010 SUB: a-b, computed as a+~b+1
  - 1011 SLT: signed two's-complement compare; result is 1 when a<b, else 0, zero-extended
  - 0100 ROR: rotate a right by b[log2(WIDTH)-1:0]
  - 0101 ROL: rotate a left by b[log2(WIDTH)-1:0]
  - 0110 NOR: ~(a|b)
  - 0111 MUL: low WIDTH bits of the unsigned product a*b; upper bits discarded
  - All other codes (0011, 1000, 1001, 11xx): result is all-zeros and zero=1, with no X propagation.
- Rotate amount 0 returns a unchanged. Upper bits of b beyond the rotate field are ignored.
- SLT overflow case (e.g. 0x80000000 vs 0x00000001): the result follows true signed order (1), not the sign of the wrapped difference.
- zero is derived from the final aluresult for every operation, not from the subtractor alone.
- aluout register:
  - On posedge clk, aluout <= aluresult.
  - On reset assertion, aluout = 0 immediately, without waiting for a clock.
- holdq register:
  - On posedge clk with en=1, holdq <= aluresult.
  - With en=0, holdq holds its value.
  - On reset, holdq = 0 immediately.
- Reset dominates clk and en. While reset is high, both registers stay 0 regardless of clock edges.
- On reset deassertion, the first clock edge loads normally.
- Register outputs change only on clk rising edge or reset assertion. No glitch path from inputs to aluout/holdq.

Decomposition:
- Shared package alu_pkg:
  - 4-bit localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_ROR, ALU_ROL, ALU_NOR, ALU_MUL.
  - The aludec and this block both use alu_pkg.
- One combinational sub-module, alu_core, computes aluresult and zero.
- Two generic register sub-modules:
  - dff_rst: asynchronous reset, always loads.
  - dff_rst_en: asynchronous reset, with enable.
  - Both are parameterized by WIDTH and instantiated once each.

Test Plan:
1. Assert reset mid-run with aluout=holdq=0x12345678 and no clock edge -> both read 0x00000000 immediately. Release reset, then srca=5, srcb=7, ADD, en=1, one edge -> aluresult=12, aluout=holdq=12.
2. Arithmetic and logic, combinational checks:
   - SUB 5-5 -> 0, zero=1.
   - SUB 3-5 -> 0xFFFFFFFE, zero=0.
   - AND 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000.
   - OR of the same operands -> 0xFFF0FFF0.
   - NOR 0,0 -> 0xFFFFFFFF.
3. SLT:
   - 0xFFFFFFFF vs 1 -> 1.
   - 1 vs 0xFFFFFFFF -> 0.
   - 0x80000000 vs 1 -> 1.
   - 7 vs 7 -> 0, zero=1.
4. Rotates and multiply:
   - ROR 0x00000001 by 1 -> 0x80000000.
   - ROL 0x80000000 by 1 -> 0x00000001.
   - ROR by 32 (b=0x20) -> a unchanged.
   - MUL 0x10000*0x10000 -> 0, zero=1.
   - MUL 6*7 -> 42.
5. Enable hold: load holdq=0xAA with en=1, then 3 edges with en=0 and changing results -> holdq stays 0xAA while aluout tracks each new result. Re-enable -> holdq updates on the next edge.
6. Undefined code 1111 with any operands -> aluresult=0, zero=1, no X on outputs.
